// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Purpose:
//   Single-outstanding APB master bridging a simple valid/ready request port
//   onto a two-slave APB bus. A request is captured in IDLE, presented for one
//   SETUP cycle, then held in ACCESS until the selected slave raises PREADY or
//   the wait-state budget (TIMEOUT_CYCLES) runs out. Each transfer ends with a
//   one-cycle rsp_valid pulse carrying read data and an error flag.
//
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles with PREADY low before the transfer is
//                    aborted with an error (legal 1..255)
//
// Ports:
//   PCLK, PRESET            - clock (rising edge), async active-high reset
//   req_valid/req_ready     - request handshake; accepted when both high
//   req_write/addr/wdata    - request direction, 7-bit address, write data
//   rsp_valid/rdata/err     - one-cycle completion pulse with data and error
//   PSELECT1/PSELECT2       - APB selects, chosen by PADDR[6]
//   PENABLE/PWRITE          - APB enable and direction
//   PADDR/PWDATA            - APB address and write data
//   PREADYx/PSLVERRx/PRDATAx - per-slave ready, error and read data
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,

    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,

    output logic       PSELECT1,
    output logic       PSELECT2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [6:0] PADDR,
    output logic [7:0] PWDATA,

    input  logic       PREADY1,
    input  logic       PREADY2,
    input  logic       PSLVERR1,
    input  logic       PSLVERR2,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    // The abort fires on the low-PREADY cycle that would bring the counter
    // up to TIMEOUT_CYCLES, so the compare is against one less.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] wait_cnt;

    logic       accept;
    logic       sel_ready;
    logic       sel_err;
    logic [7:0] sel_rdata;
    logic       done;
    logic       timeout;

    // Only the slave addressed by PADDR[6] is ever listened to; the other
    // slave's inputs are masked out here.
    always_comb begin
        sel_ready = PADDR[6] ? PREADY2  : PREADY1;
        sel_err   = PADDR[6] ? PSLVERR2 : PSLVERR1;
        sel_rdata = PADDR[6] ? PRDATA2  : PRDATA1;
    end

    // Transfer events. PREADY is only meaningful in ACCESS; anything the
    // slave shows during SETUP is ignored.
    always_comb begin
        accept  = req_valid && req_ready;
        done    = (state == ACCESS) && sel_ready;
        timeout = (state == ACCESS) && !sel_ready && (wait_cnt == LAST_WAIT);
    end

    // Next-state logic for the IDLE -> SETUP -> ACCESS -> IDLE loop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // APB control outputs derive straight from the state and the held
    // address, so reset clears them the instant it forces the state to IDLE.
    always_comb begin
        PSELECT1 = (state == SETUP || state == ACCESS) && !PADDR[6];
        PSELECT2 = (state == SETUP || state == ACCESS) &&  PADDR[6];
        PENABLE  = (state == ACCESS);
    end

    // Sequential state. req_ready is registered from the next state so it
    // stays low out of reset and first rises on the edge after reset falls,
    // and it is already high in the cycle that carries rsp_valid, letting a
    // queued request be taken back-to-back.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 7'h00;
            PWDATA    <= 8'h00;
            wait_cnt  <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);

            if (accept) begin
                PWRITE   <= req_write;
                PADDR    <= req_addr;
                PWDATA   <= req_wdata;
                wait_cnt <= 8'h00;
            end else if (state == ACCESS && !sel_ready) begin
                wait_cnt <= wait_cnt + 8'h01;
            end

            rsp_valid <= done || timeout;
            if (done) begin
                rsp_err   <= sel_err;
                rsp_rdata <= PWRITE ? 8'h00 : sel_rdata;
            end else begin
                rsp_err   <= timeout;
                rsp_rdata <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Purpose:
//   Self-checking bench for apb_master. A transfer-level model predicts, for
//   each request, the phase of every cycle after acceptance (SETUP, ACCESS,
//   response) from the slave's wait count and the timeout budget, and the
//   expected response fields. Slave behaviour is driven from the same
//   transfer description; the unselected slave is fed random noise.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int TOUT = 4;

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         waits;
        bit         err;
        logic [7:0] rdata;
    } xfer_t;

    logic       PCLK;
    logic       PRESET;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSELECT1;
    logic       PSELECT2;
    logic       PENABLE;
    logic       PWRITE;
    logic [6:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY1;
    logic       PREADY2;
    logic       PSLVERR1;
    logic       PSLVERR2;
    logic [7:0] PRDATA1;
    logic [7:0] PRDATA2;

    int compared   = 0;
    int mismatched = 0;

    apb_master #(.TIMEOUT_CYCLES(TOUT)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELECT1  (PSELECT1),
        .PSELECT2  (PSELECT2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY1   (PREADY1),
        .PREADY2   (PREADY2),
        .PSLVERR1  (PSLVERR1),
        .PSLVERR2  (PSLVERR2),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2)
    );

    // 10-unit clock; stimulus changes on the falling edge.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Build a random transfer; waits above TOUT-1 exercise the timeout.
    function automatic xfer_t randXfer();
        xfer_t t;
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = 7'($urandom);
        t.wdata = 8'($urandom);
        t.waits = $urandom_range(0, 5);
        t.err   = 1'($urandom_range(0, 1));
        t.rdata = 8'($urandom);
        return t;
    endfunction

    // Random values on every slave input; the transfer task then overrides
    // the selected slave during ACCESS.
    task automatic noiseSlaves();
        PREADY1  = 1'($urandom_range(0, 1));
        PREADY2  = 1'($urandom_range(0, 1));
        PSLVERR1 = 1'($urandom_range(0, 1));
        PSLVERR2 = 1'($urandom_range(0, 1));
        PRDATA1  = 8'($urandom);
        PRDATA2  = 8'($urandom);
    endtask

    // Present a request; called just after a falling edge.
    task automatic applyStimulus(input xfer_t t);
        req_valid = 1'b1;
        req_write = t.wr;
        req_addr  = t.addr;
        req_wdata = t.wdata;
    endtask

    // Wait (bounded) for the accepting rising edge; returns just after it.
    task automatic acceptReq(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (req_ready === 1'b1) ok = 1'b1;
            @(posedge PCLK);
            if (!ok) @(negedge PCLK);
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL %s accept: req_ready never high within 20 cycles", name);
            req_valid = 1'b0;
        end
    endtask

    // Runs one accepted transfer cycle by cycle against the model, starting
    // just after the acceptance edge and ending just after the edge that
    // closes the response cycle. With chain set, the next request is
    // presented during the response cycle so it is accepted at that edge.
    task automatic runTransfer(input xfer_t t, input bit chain, input xfer_t nx, input string name);
        bit          tmo;
        int          rspCycle;
        bit          active;
        bit          rdy;
        logic [18:0] expBus;
        logic [18:0] gotBus;
        logic [9:0]  expRsp;
        logic [9:0]  gotRsp;
        tmo      = (t.waits >= TOUT);
        rspCycle = tmo ? (2 + TOUT) : (3 + t.waits);
        for (int k = 1; k <= rspCycle; k++) begin
            @(negedge PCLK);
            if (k == 1) req_valid = 1'b0;
            noiseSlaves();
            if (k >= 2 && k < rspCycle) begin
                rdy = !tmo && ((k - 1) > t.waits);
                if (t.addr[6]) begin
                    PREADY2 = rdy;
                    if (rdy) begin PSLVERR2 = t.err; PRDATA2 = t.rdata; end
                end else begin
                    PREADY1 = rdy;
                    if (rdy) begin PSLVERR1 = t.err; PRDATA1 = t.rdata; end
                end
            end
            active = (k < rspCycle);
            expBus = {active && !t.addr[6], active && t.addr[6],
                      (k >= 2) && active, t.wr, t.addr, t.wdata};
            gotBus = {PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA};
            compared++;
            if (gotBus !== expBus) begin
                mismatched++;
                $display("[TB] FAIL %s bus cycle %0d: got %h expected %h", name, k, gotBus, expBus);
            end
            if (active) begin
                compared++;
                if ({rsp_valid, req_ready} !== 2'b00) begin
                    mismatched++;
                    $display("[TB] FAIL %s busy cycle %0d: rsp_valid,req_ready got %b expected 00",
                             name, k, {rsp_valid, req_ready});
                end
            end else begin
                expRsp = {1'b1, tmo ? 1'b1 : t.err, (tmo || t.wr) ? 8'h00 : t.rdata};
                gotRsp = {rsp_valid, rsp_err, rsp_rdata};
                compared++;
                if (gotRsp !== expRsp) begin
                    mismatched++;
                    $display("[TB] FAIL %s response cycle %0d: valid,err,rdata got %h expected %h",
                             name, k, gotRsp, expRsp);
                end
                compared++;
                if (req_ready !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL %s ready in response cycle: got %b expected 1", name, req_ready);
                end
                if (chain) applyStimulus(nx);
            end
            @(posedge PCLK);
        end
    endtask

    // One cycle after the response: pulse gone, bus idle, fields held.
    task automatic checkOutput(input xfer_t t, input string name);
        logic [20:0] exp;
        logic [20:0] got;
        @(negedge PCLK);
        noiseSlaves();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, t.wr, t.addr, t.wdata};
        got = {rsp_valid, req_ready, PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s idle: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        #1;
        got = {PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
               rsp_valid, rsp_err, rsp_rdata, req_ready};
        compared++;
        if (got !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", got);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release_ready: got %b expected 0", req_ready);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL first_edge_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write_slave1();
        xfer_t t;
        t = '{wr: 1'b1, addr: 7'h05, wdata: 8'hA5, waits: 0, err: 1'b0, rdata: 8'h77};
        applyStimulus(t);
        acceptReq("write_s1");
        runTransfer(t, 1'b0, t, "write_s1");
        checkOutput(t, "write_s1");
    endtask

    task automatic test_read_waits();
        xfer_t t;
        t = '{wr: 1'b0, addr: 7'h45, wdata: 8'h11, waits: 3, err: 1'b0, rdata: 8'h3C};
        applyStimulus(t);
        acceptReq("read_s2");
        runTransfer(t, 1'b0, t, "read_s2");
        checkOutput(t, "read_s2");
    endtask

    task automatic test_timeout();
        xfer_t t;
        t = '{wr: 1'b0, addr: 7'h12, wdata: 8'h5A, waits: 1000, err: 1'b0, rdata: 8'hEE};
        applyStimulus(t);
        acceptReq("timeout");
        runTransfer(t, 1'b0, t, "timeout");
        checkOutput(t, "timeout");
    endtask

    task automatic test_back_to_back();
        xfer_t t1;
        xfer_t t2;
        t1 = '{wr: 1'b1, addr: 7'h21, wdata: 8'hC3, waits: 0, err: 1'b1, rdata: 8'h00};
        t2 = '{wr: 1'b0, addr: 7'h4A, wdata: 8'h0F, waits: 1, err: 1'b0, rdata: 8'h96};
        applyStimulus(t1);
        acceptReq("b2b_first");
        runTransfer(t1, 1'b1, t2, "b2b_first");
        runTransfer(t2, 1'b0, t2, "b2b_second");
        checkOutput(t2, "b2b_second");
    endtask

    task automatic test_reset_mid();
        xfer_t t;
        logic [31:0] got;
        t = '{wr: 1'b1, addr: 7'h33, wdata: 8'h9C, waits: 3, err: 1'b0, rdata: 8'h00};
        applyStimulus(t);
        acceptReq("reset_mid");
        @(negedge PCLK);
        req_valid = 1'b0;
        PREADY1 = 1'b0;
        PREADY2 = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        got = {PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
               rsp_valid, rsp_err, rsp_rdata, req_ready};
        compared++;
        if (got !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_async: got %h expected 0", got);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        PREADY1 = 1'b1;
        PRESET  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            compared++;
            if ({rsp_valid, PSELECT1, PENABLE} !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_no_rsp: valid,sel1,en got %b expected 000",
                         {rsp_valid, PSELECT1, PENABLE});
            end
        end
        t = '{wr: 1'b0, addr: 7'h0C, wdata: 8'h44, waits: 2, err: 1'b0, rdata: 8'hB7};
        applyStimulus(t);
        acceptReq("after_reset");
        runTransfer(t, 1'b0, t, "after_reset");
        checkOutput(t, "after_reset");
    endtask

    task automatic test_random();
        xfer_t cur;
        xfer_t nx;
        bit    chain;
        cur = randXfer();
        applyStimulus(cur);
        acceptReq("random");
        for (int i = 0; i < 40; i++) begin
            nx    = randXfer();
            chain = (i < 39) && ($urandom_range(0, 1) == 1);
            runTransfer(cur, chain, nx, "random");
            if (!chain) begin
                checkOutput(cur, "random");
                if (i < 39) begin
                    applyStimulus(nx);
                    acceptReq("random");
                end
            end
            cur = nx;
        end
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 7'h00;
        req_wdata = 8'h00;
        PREADY1   = 1'b0;
        PREADY2   = 1'b0;
        PSLVERR1  = 1'b0;
        PSLVERR2  = 1'b0;
        PRDATA1   = 8'h00;
        PRDATA2   = 8'h00;

        test_reset();
        test_write_slave1();
        test_read_waits();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS-phase wait cycles with PREADY low before the transfer is aborted; legal range 1..255.
REQ-002 SHALL have port PCLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port PRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  transfer request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  7  transfer address; bit 6 selects the slave.
REQ-008 SHALL have port req_wdata  input  8  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  8  read data; valid only while rsp_valid is high.
REQ-011 SHALL have port rsp_err  output  1  error flag; valid only while rsp_valid is high.
REQ-012 SHALL have ports PSELECT1 and PSELECT2  output  1 each  APB select, slave 1 and slave 2.
REQ-013 SHALL have ports PENABLE and PWRITE  output  1 each  APB enable and APB direction.
REQ-014 SHALL have port PADDR  output  7  APB address.
REQ-015 SHALL have port PWDATA  output  8  APB write data.
REQ-016 SHALL have ports PREADY1, PREADY2, PSLVERR1 and PSLVERR2  input  1 each  per-slave ready and error.
REQ-017 SHALL have ports PRDATA1 and PRDATA2  input  8 each  per-slave read data.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, SETUP, ACCESS.
REQ-019 SHALL drive req_ready high only in IDLE; req_valid in any other state is ignored, and the requester holds the request until it is accepted.
REQ-020 SHALL, on acceptance in IDLE, register req_write, req_addr and req_wdata into PWRITE, PADDR and PWDATA, and enter SETUP on the next cycle.
REQ-021 SHALL in SETUP assert PSELECT1 when PADDR[6]=0 or PSELECT2 when PADDR[6]=1 (never both), hold PENABLE=0, and unconditionally enter ACCESS on the next cycle.
REQ-022 SHALL in ACCESS hold the same select high with PENABLE=1, and keep PADDR, PWDATA and PWRITE stable from SETUP through the end of ACCESS.
REQ-023 SHALL sample only the PREADY, PSLVERR and PRDATA of the selected slave; unselected slave inputs have no effect.
REQ-024 SHALL complete when the selected PREADY is high at an ACCESS edge: return to IDLE, drop select and PENABLE, and pulse rsp_valid for exactly the next cycle.
REQ-025 SHALL on completion set rsp_err = selected PSLVERR; rsp_rdata = selected PRDATA for a read, 0x00 for a write.
REQ-026 SHALL count ACCESS cycles with PREADY low in an 8-bit counter cleared on entry to SETUP.
REQ-027 SHALL, when that counter reaches TIMEOUT_CYCLES, abort: enter IDLE, drop select and PENABLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0x00.
REQ-028 SHALL give a minimum latency of 3 cycles from the acceptance edge to rsp_valid high (zero-wait slave); each wait state adds 1 cycle.
REQ-029 SHALL allow a new request to be accepted in the same IDLE cycle in which rsp_valid is high.
REQ-030 SHALL hold PADDR, PWDATA and PWRITE at their last values while in IDLE; select and PENABLE are 0 in IDLE.
REQ-031 SHALL, for PREADY high in SETUP, ignore it; completion is evaluated only in ACCESS.

Reset
REQ-032 SHALL on PRESET=1 immediately, without waiting for a PCLK edge, force state IDLE, PSELECT1=PSELECT2=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, and req_ready=0.
REQ-033 SHALL, when reset is asserted mid-transfer, discard the transfer with no rsp_valid pulse.
REQ-034 SHALL drive req_ready=1 on the first PCLK edge after PRESET falls.

Verification
REQ-035 SHALL cover a write to slave 1: req addr=0x05, wdata=0xA5, PREADY1 always 1 -> PSELECT1 high 2 cycles, PENABLE high in the 2nd, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0x00.
REQ-036 SHALL cover a read from slave 2 with wait states: addr=0x45, PREADY2 low 3 ACCESS cycles, PRDATA2=0x3C -> PSELECT2 only, PADDR stable for 5 cycles, rsp_rdata=0x3C, latency 6 cycles.
REQ-037 SHALL cover timeout: TIMEOUT_CYCLES=4, PREADY1 held 0 -> abort after 4 low ACCESS cycles, rsp_valid with rsp_err=1 and rsp_rdata=0x00, select dropped.
REQ-038 SHALL cover slave error plus back-to-back requests: PSLVERR1=1 with PREADY1=1, then a second request held -> rsp_err=1, the second request accepted in the rsp_valid cycle, and its SETUP on the next cycle.
REQ-039 SHALL cover reset mid-operation: PRESET pulsed during ACCESS -> all outputs 0 asynchronously, no rsp_valid, and the next request processed normally.
